mem_bus_arbiter: RTL and testbench

Parametrised N-port arbiter that multiplexes CPU-side requesters onto the single-master memory bus. Requesters include fetch, execution/MMU load-store, and future DMA or debug ports. It grants one transaction at a time with round-robin fairness and routes the returned data to the owning port. It supports branch flush, stall and UART programming lockout. Port 0 is always the instruction-fetch port.

---
 rtl/mem_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin N-port arbiter onto a single-master memory bus.
// Optional macro ARB_TIMEOUT_EN enables the WAIT-state watchdog on timeout_err.
module mem_bus_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            programming,
  input  logic                            system_flush,
  input  logic                            system_stall,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            we_in,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_in,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wrt_data_in,
  output logic [NUM_PORTS-1:0]            grant,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rd_data_out,
  output logic                            req_valid_o,
  output logic [ADDR_WIDTH-1:0]           addr_o,
  output logic [DATA_WIDTH-1:0]           wrt_data_o,
  output logic                            we_o,
  input  logic [DATA_WIDTH-1:0]           rd_data,
  input  logic                            data_valid,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [NUM_PORTS-1:0] PORT_ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t               state_r;
  logic [PTR_W-1:0]     rr_ptr_r;
  logic [PTR_W-1:0]     owner_r;
  logic                 kill_r;

  logic [NUM_PORTS-1:0] eligible_s;
  logic [NUM_PORTS-1:0] rot_s;
  logic [PTR_W-1:0]     offset_s;
  logic [PTR_W:0]       sum_s;
  logic [PTR_W:0]       wrap_s;
  logic [PTR_W-1:0]     winner_s;
  logic                 found_s;
  logic                 kill_now_s;
  logic [PTR_W-1:0]     next_ptr_s;
  logic                 expired_s;

  // Port 0 is additionally blocked by stall and flush.
  always_comb begin
    eligible_s    = req_valid & {NUM_PORTS{~programming}};
    eligible_s[0] = req_valid[0] & ~programming & ~system_stall & ~system_flush;
  end

  // Rotate so bit 0 is the port at rr_ptr; lowest set bit is the distance to the winner.
  assign rot_s = NUM_PORTS'({eligible_s, eligible_s} >> rr_ptr_r);

  // Priority search over the rotated vector, scanning downward so the nearest port wins.
  always_comb begin
    offset_s = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      offset_s = rot_s[k] ? PTR_W'(k) : offset_s;
    end
  end

  assign sum_s      = {1'b0, rr_ptr_r} + {1'b0, offset_s};
  assign wrap_s     = (sum_s >= (PTR_W+1)'(NUM_PORTS)) ? (sum_s - (PTR_W+1)'(NUM_PORTS)) : sum_s;
  assign winner_s   = wrap_s[PTR_W-1:0];
  assign found_s    = |eligible_s;
  assign kill_now_s = kill_r | (system_flush & (owner_r == '0) & ~we_o);
  assign next_ptr_s = (owner_r == PTR_W'(NUM_PORTS - 1)) ? '0 : (owner_r + PTR_W'(1'b1));

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_r;

  // Watchdog counts WAIT cycles; it sits at zero whenever the arbiter is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= '0;
    end else if (state_r == IDLE) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
    end
  end

  assign expired_s = (state_r == WAIT) && (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
  assign expired_s        = 1'b0;
`endif

  // Arbitration FSM with all bus- and port-side outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      kill_r      <= 1'b0;
      grant       <= '0;
      rsp_valid   <= '0;
      rd_data_out <= '0;
      req_valid_o <= 1'b0;
      addr_o      <= '0;
      wrt_data_o  <= '0;
      we_o        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      grant       <= '0;
      rsp_valid   <= '0;
      req_valid_o <= 1'b0;
      timeout_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant       <= PORT_ONE << winner_s;
            req_valid_o <= 1'b1;
            addr_o      <= addr_in[winner_s*ADDR_WIDTH +: ADDR_WIDTH];
            wrt_data_o  <= wrt_data_in[winner_s*DATA_WIDTH +: DATA_WIDTH];
            we_o        <= we_in[winner_s];
            owner_r     <= winner_s;
            kill_r      <= 1'b0;
            busy        <= 1'b1;
            state_r     <= WAIT;
          end else begin
            busy        <= 1'b0;
          end
        end
        WAIT: begin
          if (data_valid) begin
            // A killed ifetch read still completes the bus handshake, silently.
            if (!kill_now_s) begin
              rsp_valid   <= PORT_ONE << owner_r;
              rd_data_out <= rd_data;
            end else begin
              rsp_valid   <= '0;
            end
            rr_ptr_r <= next_ptr_s;
            kill_r   <= 1'b0;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end else if (expired_s) begin
            timeout_err <= 1'b1;
            rr_ptr_r    <= next_ptr_s;
            kill_r      <= 1'b0;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else begin
            kill_r      <= kill_now_s;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          programming = 1'b0;
  logic          system_flush = 1'b0;
  logic          system_stall = 1'b0;
  logic [NP-1:0] req_valid = '0;
  logic [NP-1:0] we_in = '0;
  logic [NP*AW-1:0] addr_in = '0;
  logic [NP*DW-1:0] wrt_data_in = '0;
  logic [NP-1:0] grant;
  logic [NP-1:0] rsp_valid;
  logic [DW-1:0] rd_data_out;
  logic          req_valid_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wrt_data_o;
  logic          we_o;
  logic [DW-1:0] rd_data = '0;
  logic          data_valid = 1'b0;
  logic          busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .programming(programming), .system_flush(system_flush),
    .system_stall(system_stall), .req_valid(req_valid), .we_in(we_in), .addr_in(addr_in),
    .wrt_data_in(wrt_data_in), .grant(grant), .rsp_valid(rsp_valid), .rd_data_out(rd_data_out),
    .req_valid_o(req_valid_o), .addr_o(addr_o), .wrt_data_o(wrt_data_o), .we_o(we_o),
    .rd_data(rd_data), .data_valid(data_valid), .busy(busy), .timeout_err(timeout_err));

  initial forever #5 clk = ~clk;

  // Reference model: a bus that is either free or owned by one transaction.
  bit            m_wait = 1'b0;
  bit            m_kill = 1'b0;
  int            m_rr = 0;
  int            m_owner = 0;
  int            m_cnt = 0;
  logic [NP-1:0] e_grant = '0;
  logic [NP-1:0] e_rsp = '0;
  logic          e_req = 1'b0;
  logic          e_we = 1'b0;
  logic          e_busy = 1'b0;
  logic          e_to = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wd = '0;
  logic [DW-1:0] e_rd = '0;

  function automatic bit eligible(input int p);
    if (!req_valid[p] || programming) return 1'b0;
    if (p == 0 && (system_stall || system_flush)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int pick();
    for (int k = 0; k < NP; k++) if (eligible((m_rr + k) % NP)) return (m_rr + k) % NP;
    return -1;
  endfunction

  function automatic int idx_of(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    int w;
    bit killed;
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_wait = 1'b0; m_kill = 1'b0; m_rr = 0; m_owner = 0; m_cnt = 0;
      e_grant = '0; e_rsp = '0; e_req = 1'b0; e_we = 1'b0; e_to = 1'b0;
      e_addr = '0; e_wd = '0; e_rd = '0;
    end else begin
      e_grant = '0; e_rsp = '0; e_req = 1'b0; e_to = 1'b0;
      if (!m_wait) begin
        w = pick();
        if (w >= 0) begin
          e_grant[w] = 1'b1; e_req = 1'b1;
          e_addr = addr_in[w*AW +: AW]; e_wd = wrt_data_in[w*DW +: DW]; e_we = we_in[w];
          m_owner = w; m_wait = 1'b1; m_kill = 1'b0; m_cnt = 0;
        end
      end else begin
        killed = m_kill || (system_flush && m_owner == 0 && !e_we);
        m_cnt++;
        if (data_valid) begin
          if (!killed) begin e_rsp[m_owner] = 1'b1; e_rd = rd_data; end
          m_rr = (m_owner + 1) % NP; m_wait = 1'b0; m_kill = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_cnt == TO) begin
          e_to = 1'b1; m_rr = (m_owner + 1) % NP; m_wait = 1'b0; m_kill = 1'b0;
        end
`endif
        else m_kill = killed;
      end
    end
    e_busy = m_wait;
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("grant", grant, e_grant);
      check("rsp_valid", rsp_valid, e_rsp);
      check("rd_data_out", rd_data_out, e_rd);
      check("req_valid_o", req_valid_o, e_req);
      check("addr_o", addr_o, e_addr);
      check("wrt_data_o", wrt_data_o, e_wd);
      check("we_o", we_o, e_we);
      check("busy", busy, e_busy);
      check("timeout_err", timeout_err, e_to);
    end
  end

  task automatic set_req(input int p, input bit on, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[p] = on; we_in[p] = we;
    addr_in[p*AW +: AW] = a; wrt_data_in[p*DW +: DW] = d;
  endtask

  task automatic wait_grant(output int port);
    port = -1;
    for (int i = 0; i < 20 && port < 0; i++) begin
      @(negedge clk);
      if (grant != '0) port = idx_of(grant);
    end
    if (port < 0) begin
      checks++; errors++;
      $display("FAIL wait_grant: no grant within 20 cycles, got none, expected one");
    end
  endtask

  task automatic respond_now(input logic [DW-1:0] d);
    data_valid = 1'b1; rd_data = d;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0; programming = 1'b0; system_flush = 1'b0; system_stall = 1'b0;
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int p;
    int cnt;
    int order [5];
    #2 reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_grant", grant, 4'b0000);
    check("reset_busy", busy, 1'b0);
    check("reset_rd_data_out", rd_data_out, 32'h0);
    reset = 1'b1;

    // Single port-0 read with a 3-cycle memory latency.
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
    wait_grant(p);
    check("t1_port", p, 0);
    check("t1_req_valid_o", req_valid_o, 1'b1);
    check("t1_addr_o", addr_o, 32'h100);
    check("t1_we_o", we_o, 1'b0);
    req_valid[0] = 1'b0;
    repeat (2) begin @(negedge clk); check("t1_busy", busy, 1'b1); end
    @(negedge clk);
    data_valid = 1'b1; rd_data = 32'hDEADBEEF;
    @(negedge clk);
    data_valid = 1'b0;
    check("t1_rsp_valid", rsp_valid, 4'b0001);
    check("t1_rd_data_out", rd_data_out, 32'hDEADBEEF);
    check("t1_busy_after", busy, 1'b0);

    // Round robin with all four ports requesting continuously.
    do_reset();
    for (int i = 0; i < NP; i++) set_req(i, 1'b1, 1'b0, 32'(i * 16), 32'h0);
    for (int i = 0; i < 5; i++) begin
      wait_grant(p);
      order[i] = p;
      respond_now(32'(i + 1));
    end
    check("t2_order0", order[0], 0);
    check("t2_order1", order[1], 1);
    check("t2_order2", order[2], 2);
    check("t2_order3", order[3], 3);
    check("t2_order4", order[4], 0);
    req_valid = '0;

    // Flush kills a port-0 read but never a write.
    set_req(0, 1'b1, 1'b0, 32'h300, 32'h0);
    wait_grant(p);
    check("t3_port0", p, 0);
    req_valid[0] = 1'b0;
    system_flush = 1'b1;
    @(negedge clk);
    system_flush = 1'b0;
    respond_now(32'h1234);
    check("t3_killed_rsp", rsp_valid, 4'b0000);
    check("t3_busy", busy, 1'b0);
    set_req(1, 1'b1, 1'b1, 32'h200, 32'h55);
    wait_grant(p);
    check("t3_port1", p, 1);
    check("t3_addr_o", addr_o, 32'h200);
    check("t3_we_o", we_o, 1'b1);
    check("t3_wrt_data_o", wrt_data_o, 32'h55);
    req_valid[1] = 1'b0;
    system_flush = 1'b1;
    respond_now(32'hAAAA);
    system_flush = 1'b0;
    check("t3_write_rsp", rsp_valid, 4'b0010);
    set_req(0, 1'b1, 1'b0, 32'h304, 32'h0);
    wait_grant(p);
    req_valid[0] = 1'b0;
    system_flush = 1'b1;
    respond_now(32'h5678);
    system_flush = 1'b0;
    check("t3_simul_flush_rsp", rsp_valid, 4'b0000);

    // Programming lockout, then stall steering to port 1.
    programming = 1'b1;
    req_valid = 4'b1111;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (grant != '0) cnt++; end
    check("t4_locked_grants", cnt, 0);
    programming = 1'b0;
    @(negedge clk);
    check("t4_release_grant", grant, 4'b0010);
    rd_data = 32'hCAFE0001;
    respond_now(32'hCAFE0001);
    req_valid = 4'b0011;
    system_stall = 1'b1;
    @(negedge clk);
    check("t4_stall_grant", grant, 4'b0010);
    respond_now(32'h77);
    system_stall = 1'b0;
    req_valid = '0;

    // Asynchronous reset in the middle of a port-1 transaction.
    set_req(1, 1'b1, 1'b0, 32'h400, 32'h0);
    wait_grant(p);
    check("t5_port1", p, 1);
    req_valid[1] = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("t5_grant", grant, 4'b0000);
    check("t5_req_valid_o", req_valid_o, 1'b0);
    check("t5_addr_o", addr_o, 32'h0);
    check("t5_busy", busy, 1'b0);
    check("t5_rd_data_out", rd_data_out, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    respond_now(32'hBAD);
    check("t5_stray_rsp", rsp_valid, 4'b0000);
    req_valid = 4'b0011;
    @(negedge clk);
    check("t5_first_grant", grant, 4'b0001);
    respond_now(32'h99);
    req_valid = '0;

`ifdef ARB_TIMEOUT_EN
    // Watchdog expiry after TO silent WAIT cycles.
    set_req(1, 1'b1, 1'b0, 32'h500, 32'h0);
    wait_grant(p);
    req_valid[1] = 1'b0;
    repeat (TO - 1) begin @(negedge clk); check("t6_no_timeout", timeout_err, 1'b0); end
    @(negedge clk);
    check("t6_timeout", timeout_err, 1'b1);
    check("t6_no_rsp", rsp_valid, 4'b0000);
    req_valid = 4'b1111;
    @(negedge clk);
    check("t6_next_grant", grant, 4'b0100);
    respond_now(32'h1);
    req_valid = '0;
`endif

    // Randomized traffic; the requester keeps each request stable until granted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int q = 0; q < NP; q++) begin
        if (grant[q]) begin
          if ($urandom_range(0, 1) == 0) req_valid[q] = 1'b0;
          else set_req(q, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end else if (!req_valid[q] && $urandom_range(0, 3) == 0) begin
          set_req(q, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
      end
      programming  = ($urandom_range(0, 15) == 0);
      system_stall = ($urandom_range(0, 7) == 0);
      system_flush = ($urandom_range(0, 7) == 0);
      data_valid   = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      rd_data      = $urandom;
    end
    req_valid = '0; data_valid = 1'b0; programming = 1'b0;
    system_stall = 1'b0; system_flush = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
